// File: rtl/dff_mux_pkg.sv
// Shared definitions for the register/multiplexer primitive library:
// one-hot select encodings and the one-hot check used by the select checkers.
package dff_mux_pkg;

  localparam logic [1:0] SEL2_A0 = 2'b01;
  localparam logic [1:0] SEL2_A1 = 2'b10;

  localparam logic [3:0] SEL4_A0 = 4'b0001;
  localparam logic [3:0] SEL4_A1 = 4'b0010;
  localparam logic [3:0] SEL4_A2 = 4'b0100;
  localparam logic [3:0] SEL4_A3 = 4'b1000;

  // True when exactly one bit is set. Narrower selects are zero-extended by
  // the caller, which leaves their one-hot property unchanged.
  function automatic logic onehot(input logic [3:0] sel);
    return (sel != 4'b0000) && ((sel & (sel - 4'd1)) == 4'b0000);
  endfunction

endpackage

// File: rtl/DFF.sv
// Parameterised register with asynchronous active-low clear and no enable;
// hold behaviour is built externally with a feedback mux.
module DFF #(
  parameter int n = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [n-1:0] in,
  output logic [n-1:0] out
);

  logic [n-1:0] state_d;
  logic [n-1:0] state_q;

  always_comb state_d = in;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; the reset is in the sensitivity list so it acts without clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= '0;
    else        state_q <= state_d;
  end

  assign out = state_q;

endmodule

// File: rtl/Mux2.sv
// Two-input one-hot AND-OR multiplexer. No priority: an all-zero select gives
// zero and multiple set bits give the OR of the selected inputs.
module Mux2 #(
  parameter int n = 9
) (
  input  logic [n-1:0] a0,
  input  logic [n-1:0] a1,
  input  logic [1:0]   s,
  output logic [n-1:0] b
);

  assign b = ({n{s[0]}} & a0) | ({n{s[1]}} & a1);

endmodule

// File: rtl/Mux4.sv
// Four-input one-hot AND-OR multiplexer with the same non-one-hot semantics
// as Mux2: zero for an empty select, OR of inputs for multiple set bits.
module Mux4 #(
  parameter int n = 9
) (
  input  logic [n-1:0] a0,
  input  logic [n-1:0] a1,
  input  logic [n-1:0] a2,
  input  logic [n-1:0] a3,
  input  logic [3:0]   s,
  output logic [n-1:0] b
);

  assign b = ({n{s[0]}} & a0) | ({n{s[1]}} & a1) |
             ({n{s[2]}} & a2) | ({n{s[3]}} & a3);

endmodule

// File: rtl/dff_mux.sv
// Integration wrapper exposing DFF, Mux2 and Mux4 side by side, plus a
// registered flag for any select that was not exactly one-hot last cycle.
module dff_mux
  import dff_mux_pkg::*;
#(
  parameter int n = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [n-1:0] d,
  output logic [n-1:0] q,
  input  logic [n-1:0] m2_a0,
  input  logic [n-1:0] m2_a1,
  input  logic [1:0]   m2_s,
  output logic [n-1:0] m2_b,
  input  logic [n-1:0] m4_a0,
  input  logic [n-1:0] m4_a1,
  input  logic [n-1:0] m4_a2,
  input  logic [n-1:0] m4_a3,
  input  logic [3:0]   m4_s,
  output logic [n-1:0] m4_b,
  output logic         sel_err
);

  logic [0:0] sel_err_d;
  logic [0:0] sel_err_q;

  DFF  #(n) u_dff  (clk, rst_n, d, q);
  Mux2 #(n) u_mux2 (m2_a0, m2_a1, m2_s, m2_b);
  Mux4 #(n) u_mux4 (m4_a0, m4_a1, m4_a2, m4_a3, m4_s, m4_b);

  // Mux outputs stay defined for bad selects; this only reports them.
  always_comb begin
    sel_err_d = !onehot({2'b00, m2_s}) || !onehot(m4_s);
  end

  DFF #(1) u_sel_err (clk, rst_n, sel_err_d, sel_err_q);

  assign sel_err = sel_err_q[0];

endmodule

// File: tb/tb_dff_mux.sv
// Self-checking bench for dff_mux: directed table, reset/async-reset sequences,
// an n=1 instance, and randomized cycles against a behavioural model.
module tb_dff_mux;
  import dff_mux_pkg::*;

  localparam int N = 9;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] d, q;
  logic [N-1:0] m2_a0, m2_a1, m2_b;
  logic [1:0]   m2_s;
  logic [N-1:0] m4_a0, m4_a1, m4_a2, m4_a3, m4_b;
  logic [3:0]   m4_s;
  logic         sel_err;

  logic [0:0] n1_d, n1_q, n1_m2_a0, n1_m2_a1, n1_m2_b;
  logic [0:0] n1_m4_a0, n1_m4_a1, n1_m4_a2, n1_m4_a3, n1_m4_b;
  logic [1:0] n1_m2_s;
  logic [3:0] n1_m4_s;
  logic       n1_sel_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dff_mux #(.n(N)) dut (
    .clk(clk), .rst_n(rst_n), .d(d), .q(q),
    .m2_a0(m2_a0), .m2_a1(m2_a1), .m2_s(m2_s), .m2_b(m2_b),
    .m4_a0(m4_a0), .m4_a1(m4_a1), .m4_a2(m4_a2), .m4_a3(m4_a3),
    .m4_s(m4_s), .m4_b(m4_b), .sel_err(sel_err)
  );

  dff_mux #(.n(1)) dut_n1 (
    .clk(clk), .rst_n(rst_n), .d(n1_d), .q(n1_q),
    .m2_a0(n1_m2_a0), .m2_a1(n1_m2_a1), .m2_s(n1_m2_s), .m2_b(n1_m2_b),
    .m4_a0(n1_m4_a0), .m4_a1(n1_m4_a1), .m4_a2(n1_m4_a2), .m4_a3(n1_m4_a3),
    .m4_s(n1_m4_s), .m4_b(n1_m4_b), .sel_err(n1_sel_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference mux: OR of every input whose select bit is set.
  function automatic logic [N-1:0] ref_mux(input logic [3:0][N-1:0] a, input logic [3:0] s);
    logic [N-1:0] r = '0;
    for (int i = 0; i < 4; i++) if (s[i]) r |= a[i];
    return r;
  endfunction

  function automatic logic ref_err(input logic [1:0] s2, input logic [3:0] s4);
    return ($countones(s2) != 1) || ($countones(s4) != 1);
  endfunction

  typedef struct {
    logic [N-1:0] d;
    logic [1:0]   s2;
    logic [3:0]   s4;
    logic [N-1:0] exp_b2;
    logic [N-1:0] exp_b4;
    logic         exp_err;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [N-1:0] exp_q;
    logic         exp_e;
    logic [3:0][N-1:0] a4;
    logic [1:0]   s2r;
    logic [3:0]   s4r;

    vecs[0] = '{9'h001, 2'b01, 4'b0001, 9'h0F0, 9'h001, 1'b0};
    vecs[1] = '{9'h0AA, 2'b10, 4'b0010, 9'h10F, 9'h002, 1'b0};
    vecs[2] = '{9'h155, 2'b00, 4'b0100, 9'h000, 9'h004, 1'b1};
    vecs[3] = '{9'h1FF, 2'b11, 4'b1000, 9'h1FF, 9'h008, 1'b1};
    vecs[4] = '{9'h000, 2'b01, 4'b0101, 9'h0F0, 9'h005, 1'b1};
    vecs[5] = '{9'h123, 2'b01, 4'b0000, 9'h0F0, 9'h000, 1'b1};
    vecs[6] = '{9'h0C3, 2'b10, 4'b1000, 9'h10F, 9'h008, 1'b0};

    rst_n = 1'b0;
    d = 9'h1AB;
    m2_a0 = 9'h0F0; m2_a1 = 9'h10F; m2_s = 2'b00;
    m4_a0 = 9'h001; m4_a1 = 9'h002; m4_a2 = 9'h004; m4_a3 = 9'h008; m4_s = 4'b0000;
    n1_d = 1'b0; n1_m2_a0 = 1'b0; n1_m2_a1 = 1'b1; n1_m2_s = SEL2_A0;
    n1_m4_a0 = 1'b0; n1_m4_a1 = 1'b0; n1_m4_a2 = 1'b1; n1_m4_a3 = 1'b0; n1_m4_s = SEL4_A2;

    // Reset holds q and sel_err at zero through clock edges, even with bad selects.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_q", q, 9'h000);
    check("reset_sel_err", sel_err, 1'b0);
    check("reset_m2_b_follows", m2_b, 9'h000);
    m2_s = SEL2_A0; m4_s = SEL4_A0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("first_capture_q", q, 9'h1AB);
    check("first_capture_sel_err", sel_err, 1'b0);

    // Asynchronous reset between edges clears q and a set sel_err.
    @(negedge clk);
    d = 9'h055; m2_s = 2'b00;
    @(posedge clk); #1;
    check("pre_async_q", q, 9'h055);
    check("pre_async_sel_err", sel_err, 1'b1);
    #1 rst_n = 1'b0;
    m2_s = SEL2_A1;
    #1;
    check("async_q", q, 9'h000);
    check("async_sel_err", sel_err, 1'b0);
    check("async_m2_b_live", m2_b, 9'h10F);
    @(negedge clk);
    rst_n = 1'b1;
    m2_s = SEL2_A0;
    @(posedge clk); #1;
    check("post_async_q", q, 9'h055);

    // n=1 instance.
    check("n1_mux4_sel2", n1_m4_b, 1'b1);
    n1_m4_s = SEL4_A1;
    #1 check("n1_mux4_sel1", n1_m4_b, 1'b0);
    check("n1_mux2_sel0", n1_m2_b, 1'b0);
    n1_m2_s = SEL2_A1;
    #1 check("n1_mux2_sel1", n1_m2_b, 1'b1);

    // Directed table.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      d = vecs[i].d; m2_s = vecs[i].s2; m4_s = vecs[i].s4;
      #1;
      check($sformatf("vec%0d_m2_b", i), m2_b, vecs[i].exp_b2);
      check($sformatf("vec%0d_m4_b", i), m4_b, vecs[i].exp_b4);
      @(posedge clk); #1;
      check($sformatf("vec%0d_sel_err", i), sel_err, vecs[i].exp_err);
      check($sformatf("vec%0d_q", i), q, vecs[i].d);
    end

    // Randomized cycles; selects are one-hot about half the time.
    exp_q = q; exp_e = sel_err;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      check("rand_q", q, exp_q);
      check("rand_sel_err", sel_err, exp_e);
      d = N'($urandom);
      m2_a0 = N'($urandom); m2_a1 = N'($urandom);
      m4_a0 = N'($urandom); m4_a1 = N'($urandom);
      m4_a2 = N'($urandom); m4_a3 = N'($urandom);
      s2r = 2'($urandom); s4r = 4'($urandom);
      m2_s = ($urandom_range(0, 1) == 0) ? (2'b01 << $urandom_range(0, 1)) : s2r;
      m4_s = ($urandom_range(0, 1) == 0) ? (4'b0001 << $urandom_range(0, 3)) : s4r;
      #1;
      a4 = {N'(0), N'(0), m2_a1, m2_a0};
      check("rand_m2_b", m2_b, ref_mux(a4, {2'b00, m2_s}));
      a4 = {m4_a3, m4_a2, m4_a1, m4_a0};
      check("rand_m4_b", m4_b, ref_mux(a4, m4_s));
      exp_q = d;
      exp_e = ref_err(m2_s, m4_s);
    end
    @(negedge clk);
    check("rand_last_q", q, exp_q);
    check("rand_last_sel_err", sel_err, exp_e);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
